// File: rtl/ser_word_feeder.sv
// Parallel-to-serial word feeder: accepts a WIDTH-bit word on valid/ready and shifts it out MSB-first on j.
// Define SER_WORD_FEEDER_PARITY_EN to append an even-parity bit after each word.
module ser_word_feeder #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             j,
  output logic             j_valid,
  output logic             busy,
  output logic             word_done
);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_INIT = (GAP > 0) ? GW'(GAP - 1) : '0;
`ifdef SER_WORD_FEEDER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0]    gapcnt_q, gapcnt_d;
  logic             last_bit, accept, par_bit;
`ifdef SER_WORD_FEEDER_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
`ifdef SER_WORD_FEEDER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
`ifdef SER_WORD_FEEDER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Outputs decode only registered state, so there is no din->j path.
  always_comb begin
    last_bit  = (state_q == S_SHIFT) && (bitcnt_q == '0);
    busy      = (state_q != S_IDLE);
    din_ready = (state_q == S_IDLE) || (last_bit && (GAP == 0) && !PAR_EN);
    accept    = din_valid && din_ready;
`ifdef SER_WORD_FEEDER_PARITY_EN
    par_bit   = par_q;
`else
    par_bit   = 1'b0;
`endif
    j         = 1'b0;
    j_valid   = 1'b0;
    word_done = 1'b0;
    case (state_q)
      S_SHIFT: begin
        j         = sreg_q[WIDTH-1];
        j_valid   = 1'b1;
        word_done = last_bit && !PAR_EN;
      end
      S_PAR: begin
        j         = par_bit;
        j_valid   = 1'b1;
        word_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
`ifdef SER_WORD_FEEDER_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        if (bitcnt_q == '0) begin
          if (PAR_EN) begin
            state_d = S_PAR;
          end else if (GAP > 0) begin
            state_d  = S_GAP;
            gapcnt_d = GAP_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bitcnt_d = bitcnt_q - BW'(1);
        end
      end
      S_PAR: begin
        if (GAP > 0) begin
          state_d  = S_GAP;
          gapcnt_d = GAP_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gapcnt_q == '0) state_d = S_IDLE;
        else                gapcnt_d = gapcnt_q - GW'(1);
      end
      default: ;
    endcase
    // A last-bit accept overrides the exit path so the next MSB follows with no bubble.
    if (accept) begin
      state_d  = S_SHIFT;
      sreg_d   = din;
      bitcnt_d = LAST_IDX;
`ifdef SER_WORD_FEEDER_PARITY_EN
      par_d    = ^din;
`endif
    end
  end
endmodule

// File: doc/ser_word_feeder.md
Name: ser_word_feeder

Overview:
- Parallel-to-serial feeder upstream of the sequence detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clk, on serial output j.
- j drives the detector's serial input directly. Optional GAP idle cycles follow each word.
- Supports back-to-back words so that patterns spanning word boundaries stay detectable.

Parameters:
WIDTH, 8, word length in bits (>=2)
GAP, 0, idle cycles inserted after each word (j=0, j_valid=0); 0 = back-to-back capable

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-low; sampled on posedge clk
din  input  WIDTH  parallel word, sampled only on accept
din_valid  input  1  din holds a word to send
din_ready  output  1  feeder can accept a word this cycle
j  output  1  serial bit (registered); 0 when not shifting
j_valid  output  1  j carries a data (or parity) bit this cycle
busy  output  1  state != IDLE
word_done  output  1  one-cycle pulse, coincident with the last serial bit of a word

Behaviour:
- Reset: rst==0 at posedge forces state IDLE, shift reg=0, bit counter=0, gap counter=0.
  - Outputs after reset: j=0, j_valid=0, word_done=0, busy=0, din_ready=1.
  - Reset mid-word discards the partial word; no word_done is issued.
- States: IDLE, SHIFT, PAR (only with the optional feature), GAP.
- Accept: accept = din_valid && din_ready at posedge.
  - On accept: sreg<=din, bitcnt<=WIDTH-1, state<=SHIFT.
- Latency: the first bit (din[WIDTH-1]) appears on j in the cycle right after the accepting edge. Each bit is held exactly 1 cycle.
- SHIFT: j=sreg[WIDTH-1], j_valid=1.
  - Each edge: sreg<<=1 (LSB filled 0), bitcnt-=1.
  - Last bit is the cycle with bitcnt==0. In that cycle word_done=1.
- Leaving SHIFT after the last bit:
  - PAR if the feature is enabled.
  - else GAP if GAP>0 (gapcnt<=GAP-1).
  - else IDLE, or straight into a new SHIFT if accept occurs on that edge.
- din_ready:
  - 1 in IDLE.
  - 1 in the last-bit cycle of SHIFT only when GAP==0 and the feature is disabled.
  - 0 otherwise.
- Back-to-back: accept in the last-bit cycle reloads sreg on the same edge. The next word's MSB follows with zero idle cycles; j_valid stays 1 continuously.
- GAP: j=0, j_valid=0, din_ready=0.
  - Each edge gapcnt-=1; at gapcnt==0 go to IDLE. The state holds exactly GAP cycles.
- IDLE: j=0, j_valid=0.
- din_valid while din_ready==0 is ignored. The source holds it; no word is lost or duplicated.
- Counter widths: bitcnt is $clog2(WIDTH) bits; gapcnt is $clog2(GAP+1) bits (min 1).
- No arithmetic overflow paths. All outputs are registered or decoded purely from the registered state (no combinational path din->j).

Optional Feature:
- Macro: SER_WORD_FEEDER_PARITY_EN
- Defined:
  - A 1-cycle PAR state follows SHIFT. It shifts out an even-parity bit, j = XOR of all WIDTH bits of the accepted word, with j_valid=1.
  - word_done moves to the PAR cycle (no pulse on the last data bit).
  - din_ready is never asserted outside IDLE.
  - PAR then goes to GAP (GAP>0) or IDLE.
  - A parity register latched on accept holds the XOR.
- Undefined: no PAR state or parity register. The word is exactly WIDTH serial bits.

Test Plan:
- Reset/idle: hold rst=0 3 cycles with din_valid=1 -> j=0, j_valid=0, busy=0, word_done=0, din_ready=1, no accept. Release rst -> accept on the next edge.
- Single word: WIDTH=5, GAP=0, din=5'b10010 for one cycle -> j=1,0,0,1,0 over 5 consecutive cycles starting the cycle after accept. word_done only on the 5th cycle. Then j=0, busy=0.
- Back-to-back: WIDTH=5, GAP=0, din_valid held high with 5'b10010 then 5'b01001 -> continuous 10 bits 1001001001, j_valid never drops. Second accept occurs in the first word's last-bit cycle.
- Gap and backpressure: WIDTH=4, GAP=2, din=4'b1011 then 4'b0110 (valid held) -> 1011, 2 cycles j_valid=0, 1 IDLE cycle with din_ready=1, then 0110. din_ready=0 throughout SHIFT/GAP.
- Reset mid-word: WIDTH=8, din=8'hA5, rst=0 at the 3rd bit edge -> next cycle j=0, j_valid=0, busy=0, no word_done. A new word after release shifts cleanly from its MSB.
- Parity (macro defined): WIDTH=5, din=5'b10110 -> j=1,0,1,1,0,1. word_done only on the 6th cycle. din=5'b10010 -> parity bit 0.
